// File: rtl/fp_operand_classifier_if.sv
// Operand/result bus for fp_operand_classifier: input stream plus classified result stream.
// No logic; the slave modport is the classifier, the master modport is its environment.
// Both streams use valid/ready; data and flags are held while valid is high and ready is low.
interface fp_operand_classifier_if #(
  parameter int EXP_W   = 8,
  parameter int MANT_W  = 23,
  parameter int NUM_OPS = 2
);
  localparam int DATA_W = 1 + EXP_W + MANT_W;

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_OPS*DATA_W-1:0]   in_data;

  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_OPS*DATA_W-1:0]   out_data;
  logic [NUM_OPS-1:0]          out_nan;
  logic [NUM_OPS-1:0]          out_snan;
  logic [NUM_OPS-1:0]          out_inf;
  logic [NUM_OPS-1:0]          out_zero;
  logic [NUM_OPS-1:0]          out_subn;
  logic [NUM_OPS-1:0]          out_sign;
  logic [NUM_OPS-1:0]          out_op_val;
  logic                        out_any_nan;
  logic                        out_any_snan;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_nan, out_snan, out_inf, out_zero, out_subn, out_sign, out_op_val,
    output out_any_nan, out_any_snan
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_nan, out_snan, out_inf, out_zero, out_subn, out_sign, out_op_val,
    input  out_any_nan, out_any_snan
  );
endinterface

// File: rtl/fp_operand_classifier.sv
// Classifies NUM_OPS IEEE-754-style operands (qNaN/sNaN/inf/zero/subnormal/normal) and registers them.
// Latency: 1 cycle from accept to out_valid; full throughput through a main register plus one skid register.
// Backpressure: outputs hold while out_ready is low; in_ready (a flop) drops once the skid register fills.
// Optional flush-to-zero of subnormal operands in out_data when FP_CLASS_FTZ_EN is defined.
module fp_operand_classifier #(
  parameter int EXP_W   = 8,
  parameter int MANT_W  = 23,
  parameter int NUM_OPS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_operand_classifier_if.slave bus
);
  localparam int DATA_W = 1 + EXP_W + MANT_W;

  // One stored transaction: operand data plus every per-operand flag, all registered.
  typedef struct packed {
    logic [NUM_OPS*DATA_W-1:0] data;
    logic [NUM_OPS-1:0]        nan;
    logic [NUM_OPS-1:0]        snan;
    logic [NUM_OPS-1:0]        inf;
    logic [NUM_OPS-1:0]        zero;
    logic [NUM_OPS-1:0]        subn;
    logic [NUM_OPS-1:0]        sign;
    logic [NUM_OPS-1:0]        op_val;
    logic                      any_nan;
    logic                      any_snan;
  } rec_t;

  rec_t in_rec;
  rec_t m_q;
  rec_t s_q;
  logic m_full;
  logic s_full;
  logic in_ready_q;

  logic accept;
  logic m_take;
  logic m_load_s;
  logic m_load_in;
  logic s_load;
  logic m_full_nxt;
  logic s_full_nxt;

  // Classify every operand of the incoming transaction before it is stored.
  always_comb begin
    logic [DATA_W-1:0] op;
    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;
    logic              exp_ones;
    logic              exp_zero;
    logic              mant_zero;
    in_rec    = '0;
    op        = '0;
    exp_f     = '0;
    mant_f    = '0;
    exp_ones  = 1'b0;
    exp_zero  = 1'b0;
    mant_zero = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      op        = bus.in_data[i*DATA_W +: DATA_W];
      exp_f     = op[DATA_W-2:MANT_W];
      mant_f    = op[MANT_W-1:0];
      exp_ones  = &exp_f;
      exp_zero  = ~|exp_f;
      mant_zero = ~|mant_f;

      in_rec.nan[i]    = exp_ones & ~mant_zero;
      // Quiet bit is the mantissa MSB; a NaN with it clear is signalling.
      in_rec.snan[i]   = exp_ones & ~mant_zero & ~mant_f[MANT_W-1];
      in_rec.inf[i]    = exp_ones & mant_zero;
      in_rec.zero[i]   = exp_zero & mant_zero;
      in_rec.subn[i]   = exp_zero & ~mant_zero;
      in_rec.sign[i]   = op[DATA_W-1];
      in_rec.op_val[i] = ~exp_ones;

`ifdef FP_CLASS_FTZ_EN
      // Flags keep describing the original operand; only the data is flushed.
      if (exp_zero & ~mant_zero) begin
        in_rec.data[i*DATA_W +: DATA_W] = {op[DATA_W-1], {(DATA_W-1){1'b0}}};
      end else begin
        in_rec.data[i*DATA_W +: DATA_W] = op;
      end
`else
      in_rec.data[i*DATA_W +: DATA_W] = op;
`endif
    end
    in_rec.any_nan  = |in_rec.nan;
    in_rec.any_snan = |in_rec.snan;
  end

  // Decide where the accepted input and the skid entry go this cycle.
  always_comb begin
    accept     = bus.in_valid & in_ready_q;
    // M can take a new entry when it is empty or being drained this cycle.
    m_take     = ~m_full | bus.out_ready;
    m_load_s   = m_take & s_full;
    m_load_in  = m_take & ~s_full & accept;
    s_load     = ~m_take & accept;
    m_full_nxt = m_take ? (s_full | accept) : 1'b1;
    s_full_nxt = m_load_s ? 1'b0 : (s_full | s_load);
  end

  // Main/skid storage; M always holds the older entry so ordering is FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q        <= '0;
      s_q        <= '0;
      m_full     <= 1'b0;
      s_full     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (m_load_s) begin
        m_q <= s_q;
      end else if (m_load_in) begin
        m_q <= in_rec;
      end
      if (s_load) begin
        s_q <= in_rec;
      end
      m_full     <= m_full_nxt;
      s_full     <= s_full_nxt;
      // Registered copy of ~S_full so out_ready never reaches in_ready combinationally.
      in_ready_q <= ~s_full_nxt;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = m_full;
  assign bus.out_data     = m_q.data;
  assign bus.out_nan      = m_q.nan;
  assign bus.out_snan     = m_q.snan;
  assign bus.out_inf      = m_q.inf;
  assign bus.out_zero     = m_q.zero;
  assign bus.out_subn     = m_q.subn;
  assign bus.out_sign     = m_q.sign;
  assign bus.out_op_val   = m_q.op_val;
  assign bus.out_any_nan  = m_q.any_nan;
  assign bus.out_any_snan = m_q.any_snan;

endmodule

// File: tb/tb_fp_operand_classifier.sv
// Directed and streaming bench for fp_operand_classifier at default parameters (binary32, two operands).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants or come from an independent classification model.
module tb_fp_operand_classifier;
  localparam int EXP_W   = 8;
  localparam int MANT_W  = 23;
  localparam int NUM_OPS = 2;
  localparam int OBS_W   = 64 + 7*2 + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fp_operand_classifier_if #(.EXP_W(EXP_W), .MANT_W(MANT_W), .NUM_OPS(NUM_OPS)) bus ();

  fp_operand_classifier #(.EXP_W(EXP_W), .MANT_W(MANT_W), .NUM_OPS(NUM_OPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Everything the block presents, packed in a fixed order for whole-transaction compares.
  function automatic logic [OBS_W-1:0] observed();
    return {bus.out_data, bus.out_nan, bus.out_snan, bus.out_inf, bus.out_zero,
            bus.out_subn, bus.out_sign, bus.out_op_val, bus.out_any_nan, bus.out_any_snan};
  endfunction

  // Reference classification of a pair of binary32 operands, in the same order as observed().
  function automatic logic [OBS_W-1:0] model(input logic [63:0] d);
    logic [63:0] od;
    logic [1:0]  nan, snan, inf, zero, subn, sign, opv;
    logic [31:0] x;
    logic [7:0]  e;
    logic [22:0] m;
    od = d;
    nan = '0; snan = '0; inf = '0; zero = '0; subn = '0; sign = '0; opv = '0;
    for (int i = 0; i < 2; i++) begin
      x = d[i*32 +: 32];
      e = x[30:23];
      m = x[22:0];
      sign[i] = x[31];
      opv[i]  = 1'b1;
      if (e == 8'hFF) begin
        opv[i] = 1'b0;
        if (m != 23'd0) begin
          nan[i]  = 1'b1;
          snan[i] = (m[22] == 1'b0);
        end else begin
          inf[i] = 1'b1;
        end
      end else if (e == 8'h00) begin
        if (m == 23'd0) begin
          zero[i] = 1'b1;
        end else begin
          subn[i] = 1'b1;
`ifdef FP_CLASS_FTZ_EN
          od[i*32 +: 32] = {x[31], 31'd0};
`endif
        end
      end
    end
    return {od, nan, snan, inf, zero, subn, sign, opv, (nan != 2'b00), (snan != 2'b00)};
  endfunction

  function automatic logic [63:0] rand_pair();
    logic [63:0] r;
    logic [7:0]  e;
    logic [22:0] m;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      case ($urandom_range(0, 3))
        0:       e = 8'h00;
        1:       e = 8'hFF;
        default: e = 8'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       m = 23'd0;
        1:       m = 23'h400000;
        2:       m = 23'd1;
        default: m = 23'($urandom);
      endcase
      r[i*32 +: 32] = {1'($urandom), e, m};
    end
    return r;
  endfunction

  logic [63:0] vec_a, vec_b, vec_c, v;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_outputs", 128'(observed()), 128'd0);
    rst = 1'b0;

    // op0 quiet NaN, op1 signalling NaN
    bus.in_valid = 1'b1;
    bus.in_data  = {32'h7F800001, 32'h7FC00000};
    step();
    check("t1_valid", 128'(bus.out_valid), 128'd1);
    check("t1_nan", 128'(bus.out_nan), 128'b11);
    check("t1_snan", 128'(bus.out_snan), 128'b10);
    check("t1_any_snan", 128'(bus.out_any_snan), 128'd1);
    check("t1_op_val", 128'(bus.out_op_val), 128'b00);

    // op1 -inf, op0 -0
    bus.in_data = {32'hFF800000, 32'h80000000};
    step();
    check("t2_inf", 128'(bus.out_inf), 128'b10);
    check("t2_zero", 128'(bus.out_zero), 128'b01);
    check("t2_sign", 128'(bus.out_sign), 128'b11);
    check("t2_op_val", 128'(bus.out_op_val), 128'b01);
    check("t2_any_nan", 128'(bus.out_any_nan), 128'd0);

    // op1 1.0, op0 smallest subnormal
    bus.in_data = {32'h3F800000, 32'h00000001};
    step();
    check("t3_subn", 128'(bus.out_subn), 128'b01);
    check("t3_zero", 128'(bus.out_zero), 128'b00);
`ifdef FP_CLASS_FTZ_EN
    check("t3_op0_data", 128'(bus.out_data[31:0]), 128'h00000000);
`else
    check("t3_op0_data", 128'(bus.out_data[31:0]), 128'h00000001);
`endif
    check("t3_op1_data", 128'(bus.out_data[63:32]), 128'h3F800000);

    bus.in_valid = 1'b0;
    step();
    check("t3_drain", 128'(bus.out_valid), 128'd0);

    // Backpressure: A to M, B to S, C refused until space frees
    vec_a = {32'h40490FDB, 32'hC0000000};
    vec_b = {32'h007FFFFF, 32'hFFC00000};
    vec_c = {32'h7F800000, 32'h00400000};
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = vec_a;
    step();
    check("bp_a_valid", 128'(bus.out_valid), 128'd1);
    check("bp_in_ready_1", 128'(bus.in_ready), 128'd1);
    bus.in_data = vec_b;
    step();
    check("bp_in_ready_0", 128'(bus.in_ready), 128'd0);
    check("bp_a_held", 128'(observed()), 128'(model(vec_a)));
    bus.in_data = vec_c;
    step();
    check("bp_a_stable", 128'(observed()), 128'(model(vec_a)));
    check("bp_still_full", 128'(bus.in_ready), 128'd0);
    bus.out_ready = 1'b1;
    step();
    check("bp_b_out", 128'(observed()), 128'(model(vec_b)));
    check("bp_b_valid", 128'(bus.out_valid), 128'd1);
    check("bp_ready_back", 128'(bus.in_ready), 128'd1);
    step();
    check("bp_c_out", 128'(observed()), 128'(model(vec_c)));
    check("bp_c_valid", 128'(bus.out_valid), 128'd1);
    bus.in_valid = 1'b0;
    step();
    check("bp_no_dup", 128'(bus.out_valid), 128'd0);

    // Streaming: one result per cycle, one cycle behind its input
    bus.in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      v = rand_pair();
      bus.in_data = v;
      step();
      check($sformatf("stream_%0d_valid", k), 128'(bus.out_valid), 128'd1);
      check($sformatf("stream_%0d", k), 128'(observed()), 128'(model(v)));
    end
    bus.in_valid = 1'b0;
    step();
    check("stream_end", 128'(bus.out_valid), 128'd0);

    // Asynchronous reset with both entries occupied
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = vec_a;
    step();
    bus.in_data = vec_b;
    step();
    check("ar_full", 128'(bus.in_ready), 128'd0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("ar_out_valid", 128'(bus.out_valid), 128'd0);
    check("ar_in_ready", 128'(bus.in_ready), 128'd1);
    check("ar_outputs", 128'(observed()), 128'd0);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = vec_c;
    step();
    check("ar_first_valid", 128'(bus.out_valid), 128'd1);
    check("ar_first_data", 128'(observed()), 128'(model(vec_c)));
    bus.in_valid = 1'b0;
    step();
    check("ar_no_stale", 128'(bus.out_valid), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
